// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate controller.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    DENY
  } gate_state_t;

  localparam int DEF_CAPACITY    = 10;
  localparam int DEF_OPEN_CYCLES = 50;

endpackage

// File: rtl/occupancy_counter.sv
// Saturating up/down occupancy counter with full/empty decode
// and a sticky saturation error flag.
module occupancy_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             dn,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             sat_err
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign count   = cnt_q;
  assign full    = (cnt_q == CNT_W'(CAPACITY));
  assign empty   = (cnt_q == '0);
  assign sat_err = err_q;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case (1'b1)
      (up && !dn): begin
        if (full) err_d = 1'b1;
        else      cnt_d = cnt_q + 1'b1;
      end
      (dn && !up): begin
        if (empty) err_d = 1'b1;
        else       cnt_d = cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Car-park occupancy and entry-barrier controller.
// Optional PARK_STATS_EN adds peak occupancy and entry totals.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
  parameter int CNT_W       = $clog2(CAPACITY + 1),
  parameter int TMR_W       = $clog2(OPEN_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             incr,
  input  logic             decr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
`ifdef PARK_STATS_EN
  output logic [CNT_W-1:0] peak_count,
  output logic [15:0]      entries_total,
`endif
  output logic             deny,
  output logic             err
);

  gate_state_t      state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             gate_q, gate_d;
  logic             req_q;
  logic             req_rise;

  occupancy_counter #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occ (
    .clk     (clk),
    .rst     (rst),
    .up      (incr),
    .dn      (decr),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .sat_err (err)
  );

  // Sampled every cycle, so a rise seen while OPEN is consumed there.
  assign req_rise  = entry_req && !req_q;
  assign gate_open = gate_q;
  assign deny      = (state_q == DENY);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    gate_d  = gate_q;
    unique case (state_q)
      IDLE: begin
        if (req_rise) begin
          if (full) begin
            state_d = DENY;
          end else begin
            state_d = OPEN;
            gate_d  = 1'b1;
            timer_d = TMR_W'(OPEN_CYCLES);
          end
        end
      end
      OPEN: begin
        if (timer_q != '0) timer_d = timer_q - 1'b1;
        if (incr || timer_q == TMR_W'(1)) begin
          state_d = IDLE;
          gate_d  = 1'b0;
          timer_d = '0;
        end
      end
      DENY: state_d = IDLE;
      default: begin
        state_d = IDLE;
        gate_d  = 1'b0;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      gate_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      gate_q  <= gate_d;
      req_q   <= entry_req;
    end
  end

`ifdef PARK_STATS_EN
  logic [CNT_W-1:0] peak_q, peak_d;
  logic [15:0]      tot_q, tot_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc       = count + 1'b1;
  assign peak_count    = peak_q;
  assign entries_total = tot_q;

  always_comb begin
    peak_d = peak_q;
    tot_d  = tot_q;
    if (incr && (decr || !full)) tot_d = tot_q + 16'd1;
    if (incr && !decr && !full && cnt_inc > peak_q) peak_d = cnt_inc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      peak_q <= '0;
      tot_q  <= '0;
    end else begin
      peak_q <= peak_d;
      tot_q  <= tot_d;
    end
  end
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed, table-driven bench for parking_gate_ctrl.
module tb_parking_gate_ctrl;

  localparam int CAP = 10;
  localparam int OPN = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       entry_req = 1'b0;
  logic       incr = 1'b0;
  logic       decr = 1'b0;
  logic [3:0] count;
  logic       full, empty, gate_open, deny, err;
`ifdef PARK_STATS_EN
  logic [3:0]  peak_count;
  logic [15:0] entries_total;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .entry_req     (entry_req),
    .incr          (incr),
    .decr          (decr),
    .count         (count),
    .full          (full),
    .empty         (empty),
    .gate_open     (gate_open),
`ifdef PARK_STATS_EN
    .peak_count    (peak_count),
    .entries_total (entries_total),
`endif
    .deny          (deny),
    .err           (err)
  );

  typedef struct {
    logic       req, inc, dec;
    logic [3:0] cnt;
    logic       gate, dny, er;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(bit r, bit i, bit d, int c,
                              bit g, bit dn, bit e);
    vec_t v;
    v.req = r; v.inc = i; v.dec = d;
    v.cnt = 4'(c);
    v.gate = g; v.dny = dn; v.er = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int c, input bit g,
                         input bit dn, input bit e);
    chk({nm, ".count"}, 32'(count), 32'(c));
    chk({nm, ".gate"}, 32'(gate_open), 32'(g));
    chk({nm, ".deny"}, 32'(deny), 32'(dn));
    chk({nm, ".err"}, 32'(err), 32'(e));
    chk({nm, ".full"}, 32'(full), 32'(c == CAP));
    chk({nm, ".empty"}, 32'(empty), 32'(c == 0));
  endtask

  task automatic step(input logic r, input logic i, input logic d);
    @(negedge clk);
    entry_req = r; incr = i; decr = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    entry_req = 0; incr = 0; decr = 0;
    #2 rst = 1'b0;
    #10 rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 0, 1, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 2, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, 3, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0, 3, 1, 0, 0);
    vecs[4]  = mk(1, 0, 0, 3, 1, 0, 0);
    vecs[5]  = mk(1, 0, 0, 3, 1, 0, 0);
    vecs[6]  = mk(1, 0, 0, 3, 1, 0, 0);
    vecs[7]  = mk(1, 0, 0, 3, 1, 0, 0);
    vecs[8]  = mk(1, 1, 0, 4, 0, 0, 0);
    vecs[9]  = mk(1, 0, 0, 4, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 4, 0, 0, 0);
    vecs[11] = mk(0, 1, 0, 5, 0, 0, 0);
    vecs[12] = mk(0, 1, 1, 5, 0, 0, 0);
    vecs[13] = mk(0, 1, 0, 6, 0, 0, 0);
    vecs[14] = mk(0, 1, 0, 7, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 8, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 9, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 10, 0, 0, 0);
    vecs[18] = mk(1, 0, 0, 10, 0, 1, 0);
    vecs[19] = mk(1, 0, 0, 10, 0, 0, 0);
    vecs[20] = mk(0, 1, 0, 10, 0, 0, 1);
    vecs[21] = mk(0, 0, 1, 9, 0, 0, 1);
    vecs[22] = mk(0, 1, 0, 10, 0, 0, 1);
    vecs[23] = mk(1, 0, 1, 9, 0, 1, 1);
    vecs[24] = mk(0, 0, 0, 9, 0, 0, 1);
    vecs[25] = mk(1, 0, 0, 9, 1, 0, 1);
    vecs[26] = mk(0, 1, 0, 10, 0, 0, 1);

    // Asynchronous reset asserted mid-cycle, held 17ns.
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all("rst_async", 0, 0, 0, 0);
    #16 rst = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_release", 0, 0, 0, 0);

    for (int i = 0; i < 27; i++) begin
      step(vecs[i].req, vecs[i].inc, vecs[i].dec);
      chk_all($sformatf("vec%0d", i), int'(vecs[i].cnt),
              vecs[i].gate, vecs[i].dny, vecs[i].er);
    end

    // Timeout: barrier high for exactly OPN cycles.
    do_reset();
    step(1, 0, 0);
    chk_all("to_open", 0, 1, 0, 0);
    for (int k = 1; k < OPN; k++) begin
      step(1, 0, 0);
      chk($sformatf("to_hold%0d", k), 32'(gate_open), 32'd1);
    end
    step(0, 0, 0);
    chk_all("to_close", 0, 0, 0, 0);

    // Entry on the same cycle the timer expires.
    step(1, 0, 0);
    chk_all("exp_open", 0, 1, 0, 0);
    for (int k = 1; k < OPN; k++) step(1, 0, 0);
    chk("exp_last", 32'(gate_open), 32'd1);
    step(1, 1, 0);
    chk_all("exp_incr", 1, 0, 0, 0);

    // Underflow sets a sticky error.
    step(0, 0, 1);
    chk_all("dec_ok", 0, 0, 0, 0);
    step(0, 0, 1);
    chk_all("dec_uf", 0, 0, 0, 1);
    repeat (3) step(0, 0, 0);
    chk_all("uf_sticky", 0, 0, 0, 1);

    // Reset while open closes the barrier without a clock edge.
    step(0, 1, 0);
    step(1, 0, 0);
    chk_all("mid_open", 1, 1, 0, 1);
    #2 rst = 1'b0;
    #1 chk_all("mid_rst", 0, 0, 0, 0);
    #10 rst = 1'b1;
    step(0, 0, 0);
    chk_all("mid_after", 0, 0, 0, 0);

`ifdef PARK_STATS_EN
    do_reset();
    repeat (4) step(0, 1, 0);
    repeat (2) step(0, 0, 1);
    step(0, 1, 0);
    chk("st_count", 32'(count), 32'd3);
    chk("st_peak", 32'(peak_count), 32'd4);
    chk("st_total", 32'(entries_total), 32'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
